// File: rtl/countdown_ctrl.sv
// Countdown control FSM, BCD MM:SS time register and seconds prescaler.
// Optional warn output (time <= 00:10 while running) enabled by COUNTDOWN_WARN_EN.
module countdown_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int PRE_W     = 10,
  parameter int ALARM_SEC = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       tick,
  output logic       alarm,
  output logic       warn
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       ALM_N   = 4'(ALARM_SEC);

  state_e           state_q, state_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       sec_q, sec_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             alarm_q, alarm_d;
  logic [15:0]      dec_t;
  logic [3:0]       cnt_inc;
  logic             t_zero;

  function automatic logic [3:0] clamp(input logic [3:0] d,
                                       input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign dec_t   = bcd_dec({min_q, sec_q});
  assign t_zero  = ({min_q, sec_q} == 16'h0000);
  assign cnt_inc = cnt_q + 4'd1;

  // Next-state: prescaler, command handling and BCD countdown
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (state_q == S_RUN || state_q == S_DONE) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (clear) begin
      state_d = S_IDLE;
      min_d   = 8'h00;
      sec_d   = 8'h00;
      pre_d   = '0;
      cnt_d   = 4'd0;
      tick_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pre_d = '0;
          if (load) begin
            min_d = {clamp(load_min[7:4], 4'd9),
                     clamp(load_min[3:0], 4'd9)};
            sec_d = {clamp(load_sec[7:4], 4'd5),
                     clamp(load_sec[3:0], 4'd9)};
          end else if (start && !t_zero) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (tick_d) begin
            {min_d, sec_d} = dec_t;
            if (dec_t == 16'h0000) begin
              state_d = S_DONE;
              cnt_d   = 4'd0;
            end else if (pause) begin
              state_d = S_PAUSE;
            end
          end else if (pause) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (load) begin
            min_d = {clamp(load_min[7:4], 4'd9),
                     clamp(load_min[3:0], 4'd9)};
            sec_d = {clamp(load_sec[7:4], 4'd5),
                     clamp(load_sec[3:0], 4'd9)};
          end else if (start && !t_zero) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_IDLE;
            pre_d   = '0;
            cnt_d   = 4'd0;
          end else if (tick_d) begin
            if (cnt_inc == ALM_N) begin
              state_d = S_IDLE;
              pre_d   = '0;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      endcase
    end
    alarm_d = (state_d == S_DONE);
  end

  // Registered state, time, prescaler and outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      pre_q   <= '0;
      cnt_q   <= 4'd0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic warn_q, warn_d;

  assign warn_d = (state_d == S_RUN) &&
                  ({min_d, sec_d} <= 16'h0010);

  // Registered low-time warning while running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) warn_q <= 1'b0;
    else        warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign state   = state_q;
  assign tick    = tick_q;
  assign alarm   = alarm_q;

endmodule
